// File: rtl/cnn_pkg.sv
// Shared pixel types and helpers for the gray/conv/relu/pool pipeline stages.
// No logic; constants and a combinational unsigned max only.
package cnn_pkg;

  localparam int PIX_W      = 8;
  localparam int IMG_W_DEF  = 220;
  localparam int CONV_W_DEF = 218;
  localparam int POOL_W_DEF = 109;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic pix_t max_u(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer: 1 write port, 1 combinational read port, no reset.
// Zero read latency; no backpressure (caller guarantees write/read never collide).
module pool_line_buf #(
  parameter int DEPTH = 109,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdat
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pool over a raster pixel stream; 1 cycle from bottom-right pixel to valid_out.
// No backpressure: every valid_in pixel is consumed; out-of-window edge pixels are dropped.
module max_pool_2x2
  import cnn_pkg::*;
#(
  parameter int IMG_W  = 218,
  parameter int IMG_H  = 218,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in_pix,
  output logic              valid_out,
  output logic [DATA_W-1:0] out_pix,
  output logic              last_out
);

  localparam int PW = IMG_W / 2;
  localparam int PH = IMG_H / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = (PW > 1) ? $clog2(PW) : 1;

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW:0]   WIN_W   = (CW + 1)'(2 * PW);
  localparam logic [RW:0]   WIN_H   = (RW + 1)'(2 * PH);
  localparam logic [CW-1:0] LAST_C  = CW'(2 * PW - 1);
  localparam logic [RW-1:0] LAST_R  = RW'(2 * PH - 1);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_hold;
  logic              r_valid_out;
  logic [DATA_W-1:0] r_out_pix;
  logic              r_last_out;

  logic              w_in_win;
  logic              w_odd_col;
  logic              w_odd_row;
  logic [AW-1:0]     w_lb_addr;
  logic              w_lb_we;
  logic [DATA_W-1:0] w_hmax;
  logic [DATA_W-1:0] w_lb_rdat;

  // Widened compares keep the window test correct when 2*PW is a power of two.
  assign w_in_win  = ({1'b0, r_col} < WIN_W) && ({1'b0, r_row} < WIN_H);
  assign w_odd_col = r_col[0];
  assign w_odd_row = r_row[0];
  assign w_lb_addr = AW'(r_col >> 1);
  assign w_hmax    = max_u(r_hold, in_pix);
  assign w_lb_we   = valid_in && w_in_win && w_odd_col && !w_odd_row;

  pool_line_buf #(
    .DEPTH (PW),
    .WIDTH (DATA_W),
    .AW    (AW)
  ) u_line_buf (
    .i_clk   (clk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdat  (w_hmax),
    .i_raddr (w_lb_addr),
    .o_rdat  (w_lb_rdat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (valid_in) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_valid_out <= 1'b0;
      r_out_pix   <= '0;
      r_last_out  <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      r_last_out  <= 1'b0;
      if (valid_in && w_in_win) begin
        if (!w_odd_col) begin
          r_hold <= in_pix;
        end else if (w_odd_row) begin
          r_out_pix   <= max_u(w_lb_rdat, w_hmax);
          r_valid_out <= 1'b1;
          r_last_out  <= (r_col == LAST_C) && (r_row == LAST_R);
        end
      end
    end
  end

  assign valid_out = r_valid_out;
  assign out_pix   = r_out_pix;
  assign last_out  = r_last_out;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Scoreboard bench for max_pool_2x2 on 4x4, 5x5 and 218x218 instances.
// Expected windows are computed from the driven frame and checked on the output strobe.
module tb_max_pool_2x2;

  typedef struct {
    int         dut;
    logic [7:0] pix;
    logic       last;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vin  [3];
  logic [7:0] pin  [3];
  logic       vout [3];
  logic [7:0] pout [3];
  logic       lout [3];

  exp_t       exp_q[$];
  int         n_asrt = 0;
  int         n_fail = 0;
  int         n_out  [3];
  int         n_last [3];
  int         cyc = 0;
  logic [7:0] img [0:217][0:217];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max_pool_2x2 #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u_a (
    .clk(clk), .rst(rst), .valid_in(vin[0]), .in_pix(pin[0]),
    .valid_out(vout[0]), .out_pix(pout[0]), .last_out(lout[0]));

  max_pool_2x2 #(.IMG_W(5), .IMG_H(5), .DATA_W(8)) u_b (
    .clk(clk), .rst(rst), .valid_in(vin[1]), .in_pix(pin[1]),
    .valid_out(vout[1]), .out_pix(pout[1]), .last_out(lout[1]));

  max_pool_2x2 #(.IMG_W(218), .IMG_H(218), .DATA_W(8)) u_c (
    .clk(clk), .rst(rst), .valid_in(vin[2]), .in_pix(pin[2]),
    .valid_out(vout[2]), .out_pix(pout[2]), .last_out(lout[2]));

  // Output monitor per instance: pops the scoreboard on every strobe, flags late/missing ones.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
        if (vout[g]) begin
          n_asrt++;
          if (exp_q.size() == 0 || exp_q[0].dut != g) begin
            n_fail++;
            $display("FAIL out_spurious dut%0d cyc=%0d: got valid_out=1 pix=%0d, required valid_out=0",
                     g, cyc, pout[g]);
          end else begin
            e = exp_q.pop_front();
            n_out[g]++;
            if (lout[g]) n_last[g]++;
            if (pout[g] !== e.pix || lout[g] !== e.last || cyc != e.due) begin
              n_fail++;
              $display("FAIL out_value dut%0d: got pix=%0d last=%0b cyc=%0d, required pix=%0d last=%0b cyc=%0d",
                       g, pout[g], lout[g], cyc, e.pix, e.last, e.due);
            end
          end
        end else begin
          n_asrt++;
          if (lout[g] !== 1'b0) begin
            n_fail++;
            $display("FAIL last_without_valid dut%0d cyc=%0d: got last_out=%0b, required 0", g, cyc, lout[g]);
          end
          if (exp_q.size() > 0 && exp_q[0].dut == g && exp_q[0].due <= cyc) begin
            n_asrt++;
            n_fail++;
            $display("FAIL out_missing dut%0d cyc=%0d: got valid_out=0, required pix=%0d due cyc=%0d",
                     g, cyc, exp_q[0].pix, exp_q[0].due);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  function automatic logic [7:0] win_max(input int r, input int c);
    logic [7:0] m;
    m = img[r-1][c-1];
    if (img[r-1][c] > m) m = img[r-1][c];
    if (img[r][c-1] > m) m = img[r][c-1];
    if (img[r][c]   > m) m = img[r][c];
    return m;
  endfunction

  task automatic drive(input int d, input logic v, input logic [7:0] p);
    @(posedge clk);
    #1;
    vin[d] = v;
    pin[d] = p;
  endtask

  // Sends up to n_pix pixels of img (n_pix < 0: whole frame); toggle inserts idles and a 5-cycle gap.
  task automatic send_frame(input int d, input int w, input int h, input bit toggle, input int n_pix);
    int   pw = w / 2;
    int   ph = h / 2;
    int   sent = 0;
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (n_pix >= 0 && sent >= n_pix) return;
        if (toggle && r == 2 && c == 2) repeat (5) drive(d, 1'b0, 8'($urandom_range(255)));
        drive(d, 1'b1, img[r][c]);
        sent++;
        if ((r % 2) == 1 && (c % 2) == 1 && r < 2 * ph && c < 2 * pw) begin
          e.dut  = d;
          e.pix  = win_max(r, c);
          e.last = (r == 2 * ph - 1) && (c == 2 * pw - 1);
          e.due  = cyc + 1;
          exp_q.push_back(e);
        end
        if (toggle) drive(d, 1'b0, 8'($urandom_range(255)));
      end
    end
  endtask

  task automatic drain(input int d);
    int t = 0;
    drive(d, 1'b0, 8'd0);
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    n_asrt++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain dut%0d: got %0d outputs outstanding, required 0", d, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic fill_seq(input int w, input int h, input int base, input bit inv);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = inv ? 8'(255 - (r * w + c + base)) : 8'(r * w + c + base);
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 218; r++)
      for (int c = 0; c < 218; c++)
        img[r][c] = (r == 10) ? 8'd255 : (r == 11) ? 8'd0 : 8'($urandom_range(255));
  endtask

  task automatic check_counts(input int d, input int outs, input int lasts, input string nm);
    n_asrt++;
    if (n_out[d] != outs) begin
      n_fail++;
      $display("FAIL %s_count: got %0d outputs, required %0d", nm, n_out[d], outs);
    end
    n_asrt++;
    if (n_last[d] != lasts) begin
      n_fail++;
      $display("FAIL %s_last: got %0d last_out pulses, required %0d", nm, n_last[d], lasts);
    end
    n_out[d]  = 0;
    n_last[d] = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_asrt++;
      if (vout[g] !== 1'b0 || pout[g] !== 8'd0 || lout[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got valid=%0b pix=%0d last=%0b, required 0/0/0",
                 g, vout[g], pout[g], lout[g]);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_4x4_continuous();
    fill_seq(4, 4, 1, 1'b0);
    send_frame(0, 4, 4, 1'b0, -1);
    drain(0);
    check_counts(0, 4, 1, "cont4x4");
  endtask

  task automatic test_4x4_gaps();
    fill_seq(4, 4, 1, 1'b0);
    send_frame(0, 4, 4, 1'b1, -1);
    drain(0);
    check_counts(0, 4, 1, "gaps4x4");
  endtask

  task automatic test_back_to_back();
    fill_seq(4, 4, 1, 1'b0);
    send_frame(0, 4, 4, 1'b0, -1);
    fill_seq(4, 4, 1, 1'b1);
    send_frame(0, 4, 4, 1'b0, -1);
    drain(0);
    check_counts(0, 8, 2, "b2b4x4");
  endtask

  task automatic test_odd_5x5();
    fill_seq(5, 5, 0, 1'b0);
    send_frame(1, 5, 5, 1'b0, -1);
    fill_seq(5, 5, 0, 1'b1);
    send_frame(1, 5, 5, 1'b0, -1);
    drain(1);
    check_counts(1, 8, 2, "odd5x5");
  endtask

  task automatic test_reset_mid_frame();
    fill_rand();
    send_frame(2, 218, 218, 1'b0, 57 * 218 + 101);
    @(posedge clk);
    #1;
    vin[2] = 1'b0;
    rst    = 1'b1;
    check_counts(2, 3102, 0, "aborted");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_asrt++;
      if (vout[2] !== 1'b0 || pout[2] !== 8'd0 || lout[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL in_reset cyc=%0d: got valid=%0b pix=%0d last=%0b, required 0/0/0",
                 cyc, vout[2], pout[2], lout[2]);
      end
    end
    exp_q.delete();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fill_rand();
    send_frame(2, 218, 218, 1'b0, -1);
    drain(2);
    check_counts(2, 11881, 1, "full218");
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      vin[g]    = 1'b0;
      pin[g]    = 8'd0;
      n_out[g]  = 0;
      n_last[g] = 0;
    end
    test_reset();
    test_4x4_continuous();
    test_4x4_gaps();
    test_back_to_back();
    test_odd_5x5();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
